// File: rtl/dds_cfg_sequencer.sv
// dds_cfg_sequencer: glitch-free DDS reconfiguration, loading new words only at a phase wrap.
// Optional soft amplitude ramp down/up around the load is enabled by defining DDS_SOFT_RAMP_EN.
module dds_cfg_sequencer #(
    parameter logic [15:0] RAMP_STEP    = 16'h0100,
    parameter int          RAMP_DIV     = 16,
    parameter logic [23:0] WRAP_TIMEOUT = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_ok,
    input  logic [23:0] freq_in,
    input  logic [7:0]  wave_in,
    input  logic [15:0] amp_in,
    input  logic        phase_wrap,
    output logic [23:0] fre_dat,
    output logic [7:0]  pic_dat,
    output logic [15:0] amp_dat,
    output logic        busy,
    output logic        upd_done,
    output logic        cfg_err
);
    typedef enum logic [2:0] {IDLE, RAMP_DN, WAIT_WRAP, LOAD, RAMP_UP} state_t;
    state_t state, state_nx;
    logic spi_prev, spi_edge, cap, pending, done, wait_go;
    logic [23:0] sh_freq, to_cnt;
    logic [7:0] sh_wave;
    logic [15:0] sh_amp, amp_nx;
    assign spi_edge = spi_ok & ~spi_prev;
    assign cap = spi_edge && wave_in <= 8'd3;
    assign busy = state != IDLE;
    assign wait_go = phase_wrap || to_cnt == WRAP_TIMEOUT - 24'd1;
`ifdef DDS_SOFT_RAMP_EN
    logic [15:0] target, div_cnt;
    logic [16:0] sum;
    logic tick;
    assign tick = div_cnt == 16'(RAMP_DIV - 1);
    // 17-bit sum so ramping up never wraps past 16'hFFFF
    assign sum = {1'b0, amp_dat} + {1'b0, RAMP_STEP};
    assign done = state == RAMP_UP && amp_dat == target;
    always_comb begin
        state_nx = state;
        amp_nx = amp_dat;
        case (state)
            IDLE:      if (pending) state_nx = RAMP_DN;
            RAMP_DN:   if (amp_dat == 16'd0) state_nx = WAIT_WRAP;
                       else if (tick) amp_nx = amp_dat >= RAMP_STEP ? amp_dat - RAMP_STEP : 16'd0;
            WAIT_WRAP: if (wait_go) state_nx = LOAD;
            LOAD:      state_nx = RAMP_UP;
            RAMP_UP:   if (amp_dat == target) state_nx = IDLE;
                       else if (tick) amp_nx = sum > {1'b0, target} ? target : sum[15:0];
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            target <= '0;
            div_cnt <= '0;
        end else begin
            if (state == LOAD) target <= sh_amp;
            div_cnt <= (state_nx != state || tick) ? 16'd0 : div_cnt + 16'd1;
        end
    end
`else
    assign done = state == LOAD;
    assign amp_nx = state == LOAD ? sh_amp : amp_dat;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (pending) state_nx = WAIT_WRAP;
            WAIT_WRAP: if (wait_go) state_nx = LOAD;
            default:   state_nx = IDLE;
        endcase
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            spi_prev <= 1'b1;
            pending <= 1'b0;
            sh_freq <= '0;
            sh_wave <= '0;
            sh_amp <= '0;
            fre_dat <= '0;
            pic_dat <= '0;
            amp_dat <= '0;
            upd_done <= 1'b0;
            cfg_err <= 1'b0;
            to_cnt <= '0;
        end else begin
            state <= state_nx;
            spi_prev <= spi_ok;
            if (cap) begin
                sh_freq <= freq_in;
                sh_wave <= wave_in;
                sh_amp <= amp_in;
            end
            // a capture landing on the LOAD cycle keeps the request pending
            pending <= cap | (pending & (state != LOAD));
            if (state == LOAD) begin
                fre_dat <= sh_freq;
                pic_dat <= sh_wave;
            end
            amp_dat <= amp_nx;
            upd_done <= done;
            cfg_err <= spi_edge && wave_in > 8'd3;
            to_cnt <= (state == WAIT_WRAP && state_nx == WAIT_WRAP) ? to_cnt + 24'd1 : 24'd0;
        end
    end
endmodule

// File: tb/tb_dds_cfg_sequencer.sv
// tb_dds_cfg_sequencer: directed checks of capture, wrap-aligned load, timeout, back-to-back and reset.
module tb_dds_cfg_sequencer;
    logic clk = 1'b0;
    logic rst, spi_ok, phase_wrap, busy, upd_done, cfg_err;
    logic [23:0] freq_in, fre_dat;
    logic [7:0] wave_in, pic_dat;
    logic [15:0] amp_in, amp_dat;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dds_cfg_sequencer #(.RAMP_STEP(16'h0100), .RAMP_DIV(16), .WRAP_TIMEOUT(24'd20)) dut (
        .clk(clk), .rst(rst), .spi_ok(spi_ok), .freq_in(freq_in), .wave_in(wave_in),
        .amp_in(amp_in), .phase_wrap(phase_wrap), .fre_dat(fre_dat), .pic_dat(pic_dat),
        .amp_dat(amp_dat), .busy(busy), .upd_done(upd_done), .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [23:0] f, input logic [7:0] w, input logic [15:0] a);
        spi_ok = 1'b0;
        step();
        freq_in = f;
        wave_in = w;
        amp_in = a;
        spi_ok = 1'b1;
        step();
    endtask

    task automatic wrap();
        phase_wrap = 1'b1;
        step();
        phase_wrap = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        spi_ok = 1'b1;
        phase_wrap = 1'b0;
        freq_in = 24'h00ABCD;
        wave_in = 8'd2;
        amp_in = 16'h1111;
        step(3);
        chk("rst_fre", fre_dat, 0);
        chk("rst_pic", pic_dat, 0);
        chk("rst_amp", amp_dat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", upd_done, 0);
        chk("rst_err", cfg_err, 0);
        rst = 1'b0;
        step(3);
        chk("held_spi_no_capture", busy, 0);
`ifdef DDS_SOFT_RAMP_EN
        req(24'h001000, 8'd1, 16'h0800);
        step();
        chk("r1_ramp_dn_busy", busy, 1);
        step();
        wrap();
        chk("r1_load_fre_old", fre_dat, 0);
        step();
        chk("r1_fre", fre_dat, 24'h001000);
        chk("r1_pic", pic_dat, 1);
        step(127);
        chk("r1_amp_mid", amp_dat, 16'h0700);
        step();
        chk("r1_amp_top", amp_dat, 16'h0800);
        chk("r1_done_early", upd_done, 0);
        step();
        chk("r1_done", upd_done, 1);
        chk("r1_idle", busy, 0);
        req(24'h002000, 8'd0, 16'h0400);
        step();
        step(127);
        chk("r2_amp_last", amp_dat, 16'h0100);
        step();
        chk("r2_amp_zero", amp_dat, 0);
        chk("r2_fre_hold", fre_dat, 24'h001000);
        step();
        wrap();
        chk("r2_fre_hold_load", fre_dat, 24'h001000);
        step();
        chk("r2_fre", fre_dat, 24'h002000);
        step(64);
        chk("r2_amp_top", amp_dat, 16'h0400);
        step();
        chk("r2_done", upd_done, 1);
        req(24'h333333, 8'd2, 16'h0042);
        step(21);
        chk("rmid_amp", amp_dat, 16'h0300);
        chk("rmid_busy", busy, 1);
`else
        req(24'h001000, 8'd1, 16'h0800);
        chk("t1_capture_idle", busy, 0);
        step();
        chk("t1_wait_busy", busy, 1);
        chk("t1_fre_before_wrap", fre_dat, 0);
        step(2);
        chk("t1_still_waiting", busy, 1);
        wrap();
        chk("t1_load_fre_old", fre_dat, 0);
        step();
        chk("t1_fre", fre_dat, 24'h001000);
        chk("t1_pic", pic_dat, 1);
        chk("t1_amp", amp_dat, 16'h0800);
        chk("t1_done", upd_done, 1);
        chk("t1_idle", busy, 0);
        step();
        chk("t1_done_pulse", upd_done, 0);
        req(24'hABCDEF, 8'd5, 16'h9999);
        chk("t2_err", cfg_err, 1);
        chk("t2_no_busy", busy, 0);
        step();
        chk("t2_err_pulse", cfg_err, 0);
        chk("t2_not_pending", busy, 0);
        chk("t2_fre_hold", fre_dat, 24'h001000);
        chk("t2_amp_hold", amp_dat, 16'h0800);
        req(24'h000ABC, 8'd2, 16'h1234);
        step();
        step(19);
        chk("t3_wait_20th", busy, 1);
        chk("t3_fre_hold", fre_dat, 24'h001000);
        step();
        chk("t3_load_fre_old", fre_dat, 24'h001000);
        step();
        chk("t3_timeout_fre", fre_dat, 24'h000ABC);
        chk("t3_timeout_amp", amp_dat, 16'h1234);
        chk("t3_done", upd_done, 1);
        req(24'h111111, 8'd0, 16'h0001);
        spi_ok = 1'b0;
        step();
        wrap();
        freq_in = 24'h222222;
        wave_in = 8'd3;
        amp_in = 16'hFFFF;
        spi_ok = 1'b1;
        step();
        chk("t4_old_shadow", fre_dat, 24'h111111);
        chk("t4_done", upd_done, 1);
        step();
        chk("t4_restart", busy, 1);
        chk("t4_fre_hold", fre_dat, 24'h111111);
        wrap();
        step();
        chk("t4_fre2", fre_dat, 24'h222222);
        chk("t4_pic2", pic_dat, 3);
        chk("t4_amp2", amp_dat, 16'hFFFF);
        req(24'h333333, 8'd2, 16'h0042);
        step();
        chk("tmid_busy", busy, 1);
`endif
        rst = 1'b1;
        step();
        chk("mid_rst_fre", fre_dat, 0);
        chk("mid_rst_pic", pic_dat, 0);
        chk("mid_rst_amp", amp_dat, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", upd_done, 0);
        rst = 1'b0;
        step(3);
        chk("post_rst_idle", busy, 0);
        chk("post_rst_no_done", upd_done, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
